// File: rtl/video_timing_decoder.sv
// Receive-side decoder for the DE/HS/VS + 24-bit RGB video bus: pixel X/Y, frame geometry, lock.
// Latency: pix_valid/pix_rgb/X/Y 2 clocks after the inputs; measurements/frame_start 2 clocks after VS edge.
// Backpressure: none, free-running at pixel rate. `define FRAME_CRC_EN adds frame_crc (CRC-16-CCITT per frame).
module video_timing_decoder #(
    parameter int CW          = 12,
    parameter int HS_POL      = 1,
    parameter int VS_POL      = 1,
    parameter int LOCK_FRAMES = 3
) (
    input  logic          hdmi_clk,
    input  logic          reset_n,
    input  logic          vga_de,
    input  logic          vga_hs,
    input  logic          vga_vs,
    input  logic [23:0]   vga_rgb,
    output logic          pix_valid,
    output logic [23:0]   pix_rgb,
    output logic [CW-1:0] X,
    output logic [CW-1:0] Y,
    output logic          frame_start,
    output logic [CW-1:0] h_active,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] v_active,
    output logic [CW-1:0] v_total,
    output logic          locked,
`ifdef FRAME_CRC_EN
    output logic [15:0]   frame_crc,
`endif
    output logic          overflow
);

    localparam logic [CW-1:0] MAX    = '1;
    localparam logic [3:0]    LOCK_N = 4'(LOCK_FRAMES);

    typedef enum logic {UNLOCK, LOCKED} lock_state_t;

    // Input stage (sync normalised to active-high) and previous-sample history
    logic de_s_q, de_s_d, hs_s_q, hs_s_d, vs_s_q, vs_s_d;
    logic [23:0] rgb_s_q, rgb_s_d;
    logic de_p_q, de_p_d, hs_p_q, hs_p_d, vs_p_q, vs_p_d;
    // Pixel outputs
    logic pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
    logic [23:0] pix_rgb_q, pix_rgb_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic line_seen_q, line_seen_d;
    // Line and frame measurement
    logic [CW-1:0] de_run_q, de_run_d, h_act_line_q, h_act_line_d;
    logic [CW-1:0] hcnt_q, hcnt_d, h_tot_line_q, h_tot_line_d;
    logic [CW-1:0] vact_q, vact_d, vtot_q, vtot_d;
    logic hs_seen_q, hs_seen_d, vs_seen_q, vs_seen_d;
    logic [CW-1:0] h_active_q, h_active_d, h_total_q, h_total_d;
    logic [CW-1:0] v_active_q, v_active_d, v_total_q, v_total_d;
    // Saturation and lock tracking
    logic overflow_q, overflow_d, sat_frame_q, sat_frame_d, sat_now;
    lock_state_t state_q, state_d;
    logic [3:0] lock_cnt_q, lock_cnt_d;
    logic locked_q, locked_d, frame_ok, match;
    logic de_rise, de_fall, hs_edge, vs_edge;
`ifdef FRAME_CRC_EN
    logic [15:0] crc_run_q, crc_run_d, frame_crc_q, frame_crc_d, crc_base;

    // CRC-16-CCITT over one 24-bit pixel, MSB first
    function automatic logic [15:0] crc24(input logic [15:0] c, input logic [23:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 23; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction
`endif

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == MAX) ? v : v + CW'(1);
    endfunction

    assign de_rise = de_s_q & ~de_p_q;
    assign de_fall = ~de_s_q & de_p_q;
    assign hs_edge = hs_s_q & ~hs_p_q;
    assign vs_edge = vs_s_q & ~vs_p_q;

    // Next-state: input capture, pixel coordinates, measurements and lock decision
    always_comb begin
        de_s_d  = vga_de;
        hs_s_d  = (HS_POL != 0) ? vga_hs : ~vga_hs;
        vs_s_d  = (VS_POL != 0) ? vga_vs : ~vga_vs;
        rgb_s_d = vga_rgb;
        de_p_d  = de_s_q;
        hs_p_d  = hs_s_q;
        vs_p_d  = vs_s_q;

        pix_valid_d   = de_s_q;
        pix_rgb_d     = rgb_s_q;
        frame_start_d = vs_edge;

        // X restarts on each DE run; held through blanking
        x_d = x_q;
        if (de_rise)     x_d = '0;
        else if (de_s_q) x_d = sat_inc(x_q);

        // Y restarts on the first DE line after a VS edge (VS handled before a coincident DE rise)
        y_d         = y_q;
        line_seen_d = line_seen_q & ~vs_edge;
        if (de_rise) begin
            y_d         = line_seen_d ? sat_inc(y_q) : '0;
            line_seen_d = 1'b1;
        end

        de_run_d = de_run_q;
        if (de_rise)     de_run_d = CW'(1);
        else if (de_s_q) de_run_d = sat_inc(de_run_q);
        h_act_line_d = de_fall ? de_run_q : h_act_line_q;

        // Line period only measured once an HS edge has given a reference
        hs_seen_d    = hs_seen_q | hs_edge;
        hcnt_d       = hcnt_q;
        h_tot_line_d = h_tot_line_q;
        if (hs_edge) begin
            hcnt_d = CW'(1);
            if (hs_seen_q) h_tot_line_d = hcnt_q;
        end else if (hs_seen_q) begin
            hcnt_d = sat_inc(hcnt_q);
        end

        // A coincident HS/DE edge belongs to the frame that this VS edge opens
        vs_seen_d = vs_seen_q | vs_edge;
        vact_d    = vact_q;
        vtot_d    = vtot_q;
        if (vs_edge) begin
            vact_d = de_rise ? CW'(1) : '0;
            vtot_d = hs_edge ? CW'(1) : '0;
        end else if (vs_seen_q) begin
            if (de_rise) vact_d = sat_inc(vact_q);
            if (hs_edge) vtot_d = sat_inc(vtot_q);
        end

        sat_now = (x_d == MAX) | (y_d == MAX) | (de_run_d == MAX) |
                  (hcnt_d == MAX) | (vact_d == MAX) | (vtot_d == MAX);
        overflow_d  = overflow_q | sat_now;
        sat_frame_d = vs_edge ? sat_now : (sat_frame_q | sat_now);

        // A frame with no video, no line reference or a saturated count can never match
        frame_ok = (vact_q != '0) && (h_tot_line_q != '0) && !sat_frame_q;
        match    = frame_ok && (h_act_line_q == h_active_q) && (h_tot_line_q == h_total_q) &&
                   (vact_q == v_active_q) && (vtot_q == v_total_q);

        h_active_d = h_active_q;
        h_total_d  = h_total_q;
        v_active_d = v_active_q;
        v_total_d  = v_total_q;
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        // The first VS edge after reset only opens a frame; nothing is published
        if (vs_edge && vs_seen_q) begin
            h_active_d = h_act_line_q;
            h_total_d  = h_tot_line_q;
            v_active_d = vact_q;
            v_total_d  = vtot_q;
            if (state_q == LOCKED) begin
                if (!match) begin
                    state_d    = UNLOCK;
                    lock_cnt_d = 4'd1;
                    locked_d   = 1'b0;
                end
            end else if (match) begin
                lock_cnt_d = lock_cnt_q + 4'd1;
                if (lock_cnt_d == LOCK_N) begin
                    state_d  = LOCKED;
                    locked_d = 1'b1;
                end
            end else begin
                lock_cnt_d = 4'd1;
                if (frame_ok && LOCK_N == 4'd1) begin
                    state_d  = LOCKED;
                    locked_d = 1'b1;
                end
            end
        end

`ifdef FRAME_CRC_EN
        crc_base    = vs_edge ? 16'hFFFF : crc_run_q;
        crc_run_d   = de_s_q ? crc24(crc_base, rgb_s_q) : crc_base;
        frame_crc_d = (vs_edge && vs_seen_q) ? crc_run_q : frame_crc_q;
`endif
    end

    // State registers with asynchronous clear
    always_ff @(posedge hdmi_clk or negedge reset_n) begin
        if (!reset_n) begin
            de_s_q <= 1'b0; hs_s_q <= 1'b0; vs_s_q <= 1'b0; rgb_s_q <= '0;
            de_p_q <= 1'b0; hs_p_q <= 1'b0; vs_p_q <= 1'b0;
            pix_valid_q <= 1'b0; pix_rgb_q <= '0; frame_start_q <= 1'b0;
            x_q <= '0; y_q <= '0; line_seen_q <= 1'b0;
            de_run_q <= '0; h_act_line_q <= '0; hcnt_q <= '0; h_tot_line_q <= '0;
            vact_q <= '0; vtot_q <= '0; hs_seen_q <= 1'b0; vs_seen_q <= 1'b0;
            h_active_q <= '0; h_total_q <= '0; v_active_q <= '0; v_total_q <= '0;
            overflow_q <= 1'b0; sat_frame_q <= 1'b0;
            state_q <= UNLOCK; lock_cnt_q <= '0; locked_q <= 1'b0;
`ifdef FRAME_CRC_EN
            crc_run_q <= 16'hFFFF; frame_crc_q <= '0;
`endif
        end else begin
            de_s_q <= de_s_d; hs_s_q <= hs_s_d; vs_s_q <= vs_s_d; rgb_s_q <= rgb_s_d;
            de_p_q <= de_p_d; hs_p_q <= hs_p_d; vs_p_q <= vs_p_d;
            pix_valid_q <= pix_valid_d; pix_rgb_q <= pix_rgb_d; frame_start_q <= frame_start_d;
            x_q <= x_d; y_q <= y_d; line_seen_q <= line_seen_d;
            de_run_q <= de_run_d; h_act_line_q <= h_act_line_d; hcnt_q <= hcnt_d;
            h_tot_line_q <= h_tot_line_d; vact_q <= vact_d; vtot_q <= vtot_d;
            hs_seen_q <= hs_seen_d; vs_seen_q <= vs_seen_d;
            h_active_q <= h_active_d; h_total_q <= h_total_d;
            v_active_q <= v_active_d; v_total_q <= v_total_d;
            overflow_q <= overflow_d; sat_frame_q <= sat_frame_d;
            state_q <= state_d; lock_cnt_q <= lock_cnt_d; locked_q <= locked_d;
`ifdef FRAME_CRC_EN
            crc_run_q <= crc_run_d; frame_crc_q <= frame_crc_d;
`endif
        end
    end

    assign pix_valid   = pix_valid_q;
    assign pix_rgb     = pix_rgb_q;
    assign X           = x_q;
    assign Y           = y_q;
    assign frame_start = frame_start_q;
    assign h_active    = h_active_q;
    assign h_total     = h_total_q;
    assign v_active    = v_active_q;
    assign v_total     = v_total_q;
    assign locked      = locked_q;
    assign overflow    = overflow_q;
`ifdef FRAME_CRC_EN
    assign frame_crc   = frame_crc_q;
`endif

endmodule
